frame_rate_monitor: RTL

FRAME_RATE_MONITOR -- requirements
Module: frame_rate_monitor

---
 rtl/frame_rate_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/frame_rate_monitor.sv
// Counts vsync edges per fixed clk50 gate window and reports the rate in binary and on
// seven-segment digits, with running min/max and a stall flag for lost sync.
module frame_rate_monitor #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int CNT_W         = 10,
  parameter int DIGITS        = 3,
  parameter int VS_POL        = 1,
  parameter int STALL_WINDOWS = 2,
  parameter int BLANK_LZ      = 1
) (
  input  logic                  clk50,
  input  logic                  rst,
  input  logic                  vs,
  input  logic                  clr_minmax,
  output logic [CNT_W-1:0]      fps,
  output logic [CNT_W-1:0]      fps_min,
  output logic [CNT_W-1:0]      fps_max,
  output logic                  fps_valid,
  output logic                  stall,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int                  WIN_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [WIN_W-1:0]    WIN_LAST  = WIN_W'(CLK_HZ - 1);
  localparam int                  ZC_W      = (STALL_WINDOWS > 0) ? $clog2(STALL_WINDOWS + 1) : 1;
  localparam logic [ZC_W-1:0]     ZC_MAX    = ZC_W'(STALL_WINDOWS);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic                  vs_s1, vs_s2, vs_h;
  logic                  vs_edge;
  logic [WIN_W-1:0]      win_cnt;
  logic                  win_end;
  logic [CNT_W-1:0]      frame_cnt, frame_nxt;
  logic [4*DIGITS-1:0]   bcd_cnt, bcd_nxt, bcd_reg;
  logic                  carry;
  logic                  seed_pend, seeding;
  logic [ZC_W-1:0]       zero_cnt, zero_nxt;
  logic                  lead;
  logic [3:0]            digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_h  <= 1'b0;
    end else begin
      vs_s1 <= vs;
      vs_s2 <= vs_s1;
      vs_h  <= vs_s2;
    end
  end

  assign vs_edge = (VS_POL != 0) ? (vs_s2 & ~vs_h) : (~vs_s2 & vs_h);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst)          win_cnt <= '0;
    else if (win_end) win_cnt <= '0;
    else              win_cnt <= win_cnt + WIN_W'(1);
  end

  assign win_end = (win_cnt == WIN_LAST);

  // An edge in the window-end cycle is folded into the closing window via the _nxt values.
  assign frame_nxt = (vs_edge && frame_cnt != CNT_MAX) ? frame_cnt + CNT_W'(1) : frame_cnt;

  always_comb begin
    bcd_nxt = bcd_cnt;
    carry   = 1'b0;
    if (vs_edge && bcd_cnt != ALL_NINES) begin
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (bcd_cnt[4*k +: 4] == 4'd9) begin
            bcd_nxt[4*k +: 4] = 4'd0;
          end else begin
            bcd_nxt[4*k +: 4] = bcd_cnt[4*k +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  assign seeding  = seed_pend | clr_minmax;
  assign zero_nxt = (frame_nxt != '0) ? '0 :
                    (zero_cnt == ZC_MAX) ? zero_cnt : zero_cnt + ZC_W'(1);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      bcd_cnt   <= '0;
      bcd_reg   <= '0;
      fps       <= '0;
      fps_min   <= '0;
      fps_max   <= '0;
      fps_valid <= 1'b0;
      stall     <= 1'b0;
      zero_cnt  <= '0;
      seed_pend <= 1'b1;
    end else begin
      fps_valid <= win_end;
      if (win_end) begin
        frame_cnt <= '0;
        bcd_cnt   <= '0;
        fps       <= frame_nxt;
        bcd_reg   <= bcd_nxt;
        zero_cnt  <= zero_nxt;
        stall     <= (zero_nxt >= ZC_MAX);
        seed_pend <= 1'b0;
        if (seeding) begin
          fps_min <= frame_nxt;
          fps_max <= frame_nxt;
        end else begin
          if (frame_nxt < fps_min) fps_min <= frame_nxt;
          if (frame_nxt > fps_max) fps_max <= frame_nxt;
        end
      end else begin
        frame_cnt <= frame_nxt;
        bcd_cnt   <= bcd_nxt;
        if (clr_minmax) seed_pend <= 1'b1;
      end
    end
  end

  // Walk from the top digit down; blanking stops at the first nonzero digit.
  always_comb begin
    hex   = '1;
    lead  = (BLANK_LZ != 0);
    digit = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = bcd_reg[4*k +: 4];
      if (lead && k != 0 && digit == 4'd0) begin
        hex[7*k +: 7] = 7'h7F;
      end else begin
        hex[7*k +: 7] = seg7(digit);
        lead = 1'b0;
      end
    end
  end

endmodule
